// File: rtl/exec_unit_seq_if.sv
// Handshake bundle between the operand stage, the sequential execute unit
// and the writeback consumer.
interface exec_unit_seq_if #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            opcode;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [SHAMT_W-1:0]    s_r_amount;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   result;
  logic                  zero_flag;
  logic                  carry_flag;
  logic                  ac_flag;
  logic                  parity_flag;
  logic                  busy;

  modport master (
    output in_valid, opcode, op_a, op_b, s_r_amount, out_ready,
    input  in_ready, out_valid, result, zero_flag, carry_flag,
    input  ac_flag, parity_flag, busy
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, s_r_amount, out_ready,
    output in_ready, out_valid, result, zero_flag, carry_flag,
    output ac_flag, parity_flag, busy
  );
endinterface

// File: rtl/exec_unit_seq.sv
// Sequential execute stage: 1-cycle ALU ops, iterative DIV (and MUL when
// EXEC_ITER_MUL_EN is defined); result and flags held until taken.
module exec_unit_seq #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
) (
  input logic            clk,
  input logic            reset,
  exec_unit_seq_if.slave bus
);

  localparam logic [4:0] OP_MOV = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_SUB = 5'b00010;
  localparam logic [4:0] OP_MUL = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b00100;
  localparam logic [4:0] OP_INC = 5'b00101;
  localparam logic [4:0] OP_DEC = 5'b00110;
  localparam logic [4:0] OP_AND = 5'b00111;
  localparam logic [4:0] OP_OR  = 5'b01000;
  localparam logic [4:0] OP_NOT = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_ASL = 5'b10000;
  localparam logic [4:0] OP_ASR = 5'b10001;
  localparam logic [4:0] OP_LSL = 5'b10010;
  localparam logic [4:0] OP_LSR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_CMP = 5'b11001;

  localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t               state;
  logic [4:0]           op_q;
  logic [DATA_W-1:0]    b_q;
  logic [DATA_W-1:0]    hi_q;
  logic [DATA_W-1:0]    lo_q;
  logic [SHAMT_W-1:0]   cnt;
  logic [2*DATA_W-1:0]  res_q;
  logic                 z_q;
  logic                 c_q;
  logic                 ac_q;
  logic                 p_q;

  logic [DATA_W-1:0]    a;
  logic [DATA_W-1:0]    b;
  logic [SHAMT_W-1:0]   n;
  logic                 is_iter;

  assign a = bus.op_a;
  assign b = bus.op_b;
  assign n = bus.s_r_amount;

`ifdef EXEC_ITER_MUL_EN
  assign is_iter = (bus.opcode == OP_DIV) || (bus.opcode == OP_MUL);
`else
  assign is_iter = (bus.opcode == OP_DIV);
`endif

  logic [2*DATA_W-1:0]  sc_res;
  logic                 sc_c;
  logic                 sc_ac;
  logic                 sc_known;
  logic                 sc_wide;
  logic [DATA_W-1:0]    rhs;
  logic [DATA_W:0]      sum;
  logic [DATA_W:0]      diff;
  logic [4:0]           nib_s;
  logic [4:0]           nib_d;
  logic [DATA_W:0]      shl;
  logic [DATA_W:0]      shr;
  logic signed [DATA_W:0] sar;

  // Shifts carry an extra guard bit so the last bit out lands in it.
  always_comb begin
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_ac    = 1'b0;
    sc_known = 1'b1;
    sc_wide  = 1'b0;
    rhs   = (bus.opcode == OP_INC || bus.opcode == OP_DEC)
          ? DATA_W'(1) : b;
    sum   = {1'b0, a} + {1'b0, rhs};
    diff  = {1'b0, a} - {1'b0, rhs};
    nib_s = {1'b0, a[3:0]} + {1'b0, rhs[3:0]};
    nib_d = {1'b0, a[3:0]} + {1'b0, ~rhs[3:0]} + 5'd1;
    shl   = {1'b0, a} << n;
    shr   = {a, 1'b0} >> n;
    sar   = $signed({a, 1'b0}) >>> n;
    case (bus.opcode)
      OP_MOV: sc_res[DATA_W-1:0] = a;
      OP_ADD, OP_INC: begin
        sc_res[DATA_W-1:0] = sum[DATA_W-1:0];
        sc_c  = sum[DATA_W];
        sc_ac = nib_s[4];
      end
      OP_SUB, OP_DEC: begin
        sc_res[DATA_W-1:0] = diff[DATA_W-1:0];
        sc_c  = diff[DATA_W];
        sc_ac = nib_d[4];
      end
      OP_AND: sc_res[DATA_W-1:0] = a & b;
      OP_OR:  sc_res[DATA_W-1:0] = a | b;
      OP_NOT: sc_res[DATA_W-1:0] = ~a;
      OP_XOR: sc_res[DATA_W-1:0] = a ^ b;
      OP_ASL, OP_LSL: begin
        sc_res[DATA_W-1:0] = shl[DATA_W-1:0];
        sc_c = shl[DATA_W];
      end
      OP_ASR: begin
        sc_res[DATA_W-1:0] = sar[DATA_W:1];
        sc_c = sar[0];
      end
      OP_LSR: begin
        sc_res[DATA_W-1:0] = shr[DATA_W:1];
        sc_c = shr[0];
      end
      OP_ROL: sc_res[DATA_W-1:0] =
        (a << n) | (a >> (DATA_W - int'(n)));
      OP_ROR: sc_res[DATA_W-1:0] =
        (a >> n) | (a << (DATA_W - int'(n)));
      OP_CMP: sc_res[0] = (a >= b);
`ifndef EXEC_ITER_MUL_EN
      OP_MUL: begin
        sc_res  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        sc_wide = 1'b1;
      end
`endif
      default: sc_known = 1'b0;
    endcase
  end

  logic [DATA_W:0]    mul_sum;
  logic [DATA_W:0]    div_r;
  logic               div_ge;
  logic [DATA_W-1:0]  div_d;
  logic [DATA_W-1:0]  nx_hi;
  logic [DATA_W-1:0]  nx_lo;

  // hi:lo is the product/remainder:quotient pair, one bit per cycle.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_r   = {hi_q, lo_q[DATA_W-1]};
    div_ge  = div_r >= {1'b0, b_q};
    div_d   = div_r[DATA_W-1:0] - b_q;
    if (op_q == OP_DIV) begin
      nx_hi = div_ge ? div_d : div_r[DATA_W-1:0];
      nx_lo = {lo_q[DATA_W-2:0], div_ge};
    end else begin
      nx_hi = mul_sum[DATA_W:1];
      nx_lo = {mul_sum[0], lo_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt   <= '0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ac_q  <= 1'b0;
      p_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          op_q <= bus.opcode;
          b_q  <= b;
          if (is_iter) begin
            hi_q  <= '0;
            lo_q  <= a;
            cnt   <= '0;
            state <= ITER;
          end else begin
            res_q <= sc_res;
            c_q   <= sc_c;
            ac_q  <= sc_ac;
            z_q   <= sc_known & (sc_wide ? ~|sc_res
                                         : ~|sc_res[DATA_W-1:0]);
            p_q   <= sc_known & (sc_wide ? ^sc_res
                                         : ^sc_res[DATA_W-1:0]);
            state <= DONE;
          end
        end
        ITER: begin
          hi_q <= nx_hi;
          lo_q <= nx_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            res_q <= {nx_hi, nx_lo};
            ac_q  <= 1'b0;
            if (op_q == OP_DIV) begin
              z_q <= ~|nx_lo;
              p_q <= ^nx_lo;
              c_q <= ~|b_q;
            end else begin
              z_q <= ~|{nx_hi, nx_lo};
              p_q <= ^{nx_hi, nx_lo};
              c_q <= 1'b0;
            end
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.result      = res_q;
  assign bus.zero_flag   = z_q;
  assign bus.carry_flag  = c_q;
  assign bus.ac_flag     = ac_q;
  assign bus.parity_flag = p_q;

endmodule

// File: tb/tb_exec_unit_seq.sv
// Bench for exec_unit_seq: directed vector table, handshake/reset sequences
// and random ops against an arithmetic reference model.
module tb_exec_unit_seq;
  localparam int W = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exec_unit_seq_if #(.DATA_W(W), .SHAMT_W(S)) bif ();

  exec_unit_seq #(.DATA_W(W), .SHAMT_W(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [15:0] res;
    logic z;
    logic c;
    logic ac;
    logic p;
  } out_t;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] n;
    out_t       exp;
  } vec_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic out_t snap();
    out_t o;
    o.res = bif.result;
    o.z   = bif.zero_flag;
    o.c   = bif.carry_flag;
    o.ac  = bif.ac_flag;
    o.p   = bif.parity_flag;
    return o;
  endfunction

  function automatic int model_lat(logic [4:0] op);
    if (op == 5'h04) return 9;
`ifdef EXEC_ITER_MUL_EN
    if (op == 5'h03) return 9;
`endif
    return 1;
  endfunction

  function automatic out_t model(logic [4:0] op, logic [7:0] a,
                                 logic [7:0] b, logic [2:0] n);
    out_t m;
    int ua, ub, r, nn, zb;
    bit c, ac, known, wide;
    ua = int'(a); ub = int'(b); nn = int'(n);
    r = 0; c = 0; ac = 0; known = 1; wide = 0;
    case (op)
      5'h00: r = ua;
      5'h01: begin
        r = ua + ub; c = r > 255;
        ac = (ua % 16 + ub % 16) > 15; r = r % 256;
      end
      5'h02: begin
        c = ua < ub; ac = (ua % 16) >= (ub % 16);
        r = (ua - ub + 256) % 256;
      end
      5'h03: begin r = ua * ub; wide = 1; end
      5'h04: begin
        if (ub == 0) begin r = ua * 256 + 255; c = 1; end
        else r = (ua % ub) * 256 + ua / ub;
      end
      5'h05: begin
        c = ua == 255; ac = (ua % 16) == 15; r = (ua + 1) % 256;
      end
      5'h06: begin
        c = ua == 0; ac = (ua % 16) != 0; r = (ua + 255) % 256;
      end
      5'h07: r = ua & ub;
      5'h08: r = ua | ub;
      5'h09: r = 255 - ua;
      5'h0A: r = ua ^ ub;
      5'h10, 5'h12: begin
        r = ua;
        for (int i = 0; i < nn; i++) begin
          c = r >= 128; r = (r * 2) % 256;
        end
      end
      5'h11: begin
        r = ua;
        for (int i = 0; i < nn; i++) begin
          c = (r % 2) == 1; r = r / 2 + ((r >= 128) ? 128 : 0);
        end
      end
      5'h13: begin
        r = ua;
        for (int i = 0; i < nn; i++) begin
          c = (r % 2) == 1; r = r / 2;
        end
      end
      5'h14: begin
        r = ua;
        for (int i = 0; i < nn; i++) r = (r * 2) % 256 + r / 128;
      end
      5'h15: begin
        r = ua;
        for (int i = 0; i < nn; i++) r = r / 2 + (r % 2) * 128;
      end
      5'h19: r = (ua >= ub) ? 1 : 0;
      default: known = 0;
    endcase
    zb = wide ? r : r % 256;
    m.res = r[15:0];
    m.z   = known && (zb == 0);
    m.c   = c;
    m.ac  = ac;
    m.p   = known && (($countones(zb) % 2) == 1);
    return m;
  endfunction

  task automatic start_op(logic [4:0] op, logic [7:0] a,
                          logic [7:0] b, logic [2:0] n);
    int g = 0;
    @(negedge clk);
    while (!bif.in_ready && g < 50) begin
      @(negedge clk); g++;
    end
    if (!bif.in_ready) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
    bif.in_valid = 1'b1;
    bif.opcode = op; bif.op_a = a; bif.op_b = b; bif.s_r_amount = n;
    @(posedge clk);
    #1 bif.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_lo);
    lat = 1; busy_lo = 0;
    while (!bif.out_valid && lat < 40) begin
      if (!bif.busy) busy_lo++;
      @(posedge clk); #1;
      lat++;
    end
    if (!bif.out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got 0 want 1");
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    bif.out_ready = 1'b1;
    @(posedge clk);
    #1 bif.out_ready = 1'b0;
  endtask

  vec_t vt[$];

  initial begin
    int lat, bl;
    out_t held;
    logic [4:0] rop;
    logic [7:0] ra, rb;
    logic [2:0] rn;

    bif.in_valid = 0; bif.opcode = 0; bif.op_a = 0; bif.op_b = 0;
    bif.s_r_amount = 0; bif.out_ready = 0;

    vt.push_back('{5'h01, 8'hF8, 8'h0C, 3'd0, {16'h0004, 4'b0111}});
    vt.push_back('{5'h03, 8'hFF, 8'hFF, 3'd0, {16'hFE01, 4'b0000}});
    vt.push_back('{5'h04, 8'd200, 8'd7, 3'd0, {16'h041C, 4'b0001}});
    vt.push_back('{5'h04, 8'h05, 8'h00, 3'd0, {16'h05FF, 4'b0100}});
    vt.push_back('{5'h11, 8'h81, 8'h00, 3'd1, {16'h00C0, 4'b0100}});
    vt.push_back('{5'h13, 8'h81, 8'h00, 3'd1, {16'h0040, 4'b0101}});
    vt.push_back('{5'h14, 8'h81, 8'h00, 3'd1, {16'h0003, 4'b0000}});
    vt.push_back('{5'h02, 8'h10, 8'h10, 3'd0, {16'h0000, 4'b1010}});
    vt.push_back('{5'h01, 8'h01, 8'h01, 3'd0, {16'h0002, 4'b0001}});
    vt.push_back('{5'h19, 8'h05, 8'h09, 3'd0, {16'h0000, 4'b1000}});
    vt.push_back('{5'h19, 8'h09, 8'h05, 3'd0, {16'h0001, 4'b0001}});
    vt.push_back('{5'h0B, 8'h55, 8'hAA, 3'd0, {16'h0000, 4'b0000}});
    vt.push_back('{5'h12, 8'h81, 8'h00, 3'd0, {16'h0081, 4'b0000}});
    vt.push_back('{5'h09, 8'hFF, 8'h00, 3'd0, {16'h0000, 4'b1000}});
    vt.push_back('{5'h06, 8'h00, 8'h00, 3'd0, {16'h00FF, 4'b0100}});
    vt.push_back('{5'h05, 8'h0F, 8'h00, 3'd0, {16'h0010, 4'b0011}});
    vt.push_back('{5'h15, 8'h01, 8'h00, 3'd1, {16'h0080, 4'b0001}});
    vt.push_back('{5'h10, 8'h81, 8'h00, 3'd2, {16'h0004, 4'b0001}});
    vt.push_back('{5'h13, 8'h81, 8'h00, 3'd7, {16'h0001, 4'b0001}});
    vt.push_back('{5'h00, 8'h00, 8'h33, 3'd0, {16'h0000, 4'b1000}});
    vt.push_back('{5'h0A, 8'h0F, 8'hF0, 3'd0, {16'h00FF, 4'b0000}});

    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_out", {bif.result, bif.zero_flag, bif.carry_flag,
         bif.ac_flag, bif.parity_flag, bif.out_valid, bif.busy}, 0);
    chk("reset_in_ready", bif.in_ready, 1);

    foreach (vt[i]) begin
      start_op(vt[i].op, vt[i].a, vt[i].b, vt[i].n);
      wait_done(lat, bl);
      chk($sformatf("vec%0d_out", i), snap(), vt[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, model_lat(vt[i].op));
      chk($sformatf("vec%0d_busy", i), bl, 0);
      release_out();
    end
    chk("release_state", {bif.out_valid, bif.in_ready, bif.busy}, 3'b010);

    // result must stay put while the consumer stalls
    start_op(5'h02, 8'h10, 8'h10, 3'd0);
    wait_done(lat, bl);
    held = snap();
    chk("stall_first", held, {16'h0000, 4'b1010});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bif.in_valid = 1'b1; bif.opcode = 5'h01;
        bif.op_a = 8'h01; bif.op_b = 8'h01;
      end
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      chk($sformatf("stall%0d_out", k), snap(), held);
      chk($sformatf("stall%0d_hs", k),
          {bif.out_valid, bif.in_ready}, 2'b10);
    end
    release_out();
    chk("stall_release", {bif.out_valid, bif.in_ready, bif.busy}, 3'b010);
    @(posedge clk); #1;
    chk("stall_no_accept", {bif.out_valid, bif.in_ready}, 2'b01);

    // abort a DIV in its fourth iteration
    start_op(5'h04, 8'd200, 8'd7, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("div_busy", {bif.busy, bif.out_valid}, 2'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_out", {bif.result, bif.zero_flag, bif.carry_flag,
         bif.ac_flag, bif.parity_flag, bif.out_valid, bif.busy}, 0);
    chk("abort_in_ready", bif.in_ready, 1);
    @(negedge clk) reset = 1'b0;
    start_op(5'h01, 8'h01, 8'h01, 3'd0);
    wait_done(lat, bl);
    chk("after_abort_add", snap(), {16'h0002, 4'b0001});
    chk("after_abort_lat", lat, 1);
    release_out();

    for (int i = 0; i < 150; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rn  = 3'($urandom);
      start_op(rop, ra, rb, rn);
      wait_done(lat, bl);
      chk($sformatf("rnd%0d_op%0h_%0h_%0h_%0d", i, rop, ra, rb, rn),
          snap(), model(rop, ra, rb, rn));
      chk($sformatf("rnd%0d_lat", i), lat, model_lat(rop));
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_unit_seq.md
Name: exec_unit_seq

Overview:
Parametrised, sequential successor to the single-cycle execute stage of the 8-bit core. It accepts one decoded ALU operation through a valid/ready handshake and computes it in 1 cycle, or iteratively for MUL/DIV. It holds a registered result and flags until the consumer takes them. Operand fetch and addressing-mode selection are done upstream; this block sees only resolved operands, which decouples the execute stage from the register file and memory bank.

Parameters:
DATA_W, 8, operand width; power of two, at least 4.
SHAMT_W, 3, shift/rotate amount width; must equal log2(DATA_W).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  reset, synchronous, active-high.
in_valid  in  1  upstream offers an operation.
in_ready  out  1  block can accept; high only in IDLE.
opcode  in  5  operation code, using the core's existing encoding.
op_a  in  DATA_W  primary operand (destination/source-1 value, or the memory value for single-operand ops).
op_b  in  DATA_W  secondary operand.
s_r_amount  in  SHAMT_W  shift/rotate count.
out_valid  out  1  result and flags valid.
out_ready  in  1  downstream takes the result.
result  out  2*DATA_W  result; upper half is 0 except for MUL/DIV.
zero_flag, carry_flag, ac_flag, parity_flag  out  1 each  status flags.
busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ITER, DONE.
- Accept: on a clk edge with in_valid && in_ready, latch opcode, op_a, op_b and s_r_amount.
  - MUL (00011), when iterative, and DIV (00100) go to ITER.
  - All other opcodes compute at that edge and go to DONE.
- ITER runs DATA_W cycles on a counter, then goes to DONE.
  - Latency from the accept edge to out_valid: 1 cycle for single-cycle ops, DATA_W+1 cycles for iterative ops.
- DONE:
  - out_valid=1; result and flags are held stable.
  - On out_ready go to IDLE. out_valid drops at the same edge.
  - No new accept until IDLE, so peak throughput is 1 op per 2 cycles.
- Ops:
  - MOV 00000: op_a.
  - ADD 00001: a+b, carry = bit DATA_W.
  - SUB 00010: a-b, carry = borrow.
  - INC 00101: a+1. DEC 00110: a-1. Carry/borrow as for ADD/SUB.
  - AND 00111, OR 01000, NOT 01001 (~a), XOR 01010.
  - ASL 10000 and LSL 10010: a<<n, carry = last bit shifted out.
  - ASR 10001: sign-fill shift, carry = last bit out.
  - LSR 10011: zero-fill shift, carry = last bit out.
  - ROL 10100, ROR 10101: rotate by n, carry=0.
  - CMP 11001: result[0] = (a>=b) unsigned, other bits 0.
  - Shifts and rotates with n=0: result=a, carry=0.
- MUL: result = a*b, full 2*DATA_W bits, unsigned; shift-add, 1 bit per cycle.
- DIV: restoring, 1 quotient bit per cycle.
  - result[DATA_W-1:0] = quotient, result[2*DATA_W-1:DATA_W] = remainder.
  - b=0: quotient all ones, remainder = a, carry=1, still DATA_W+1 latency.
  - Otherwise carry=0.
- Unlisted opcodes (including jump/branch/halt/load/store): 1-cycle completion, result=0, all flags 0.
- Flags are registered with result and apply only to the completing op.
  - zero: result==0 over all 2*DATA_W bits for MUL, over the quotient for DIV, else over the low DATA_W bits.
  - ac: carry/borrow out of bit 3 for ADD/SUB/INC/DEC, else 0.
  - parity: XOR of the same bits used for zero (1 = odd number of ones); CMP uses result[0].
  - carry: 0 for ops not listed above.
- Reset: state=IDLE, result=0, all flags 0, out_valid=0, busy=0, in_ready=1 from the cycle after the reset edge.
  - Reset during ITER or DONE aborts the op and discards its result.
- in_valid while not ready: ignored. Upstream holds its request.

Optional Feature:
- Macro: EXEC_ITER_MUL_EN.
- Defined: MUL uses ITER, DATA_W+1 cycle latency, no DATA_W×DATA_W multiplier inferred.
- Undefined: MUL completes in 1 cycle via combinational multiply; only DIV uses ITER.
- Result and flag values are identical either way.

Test Plan (DATA_W=8):
- ADD a=0xF8 b=0x0C -> out_valid 1 cycle after accept; result=0x0004, carry=1, ac=1, zero=0, parity=1.
- MUL a=0xFF b=0xFF -> result=0xFE01, zero=0, parity=0; latency 9 with EXEC_ITER_MUL_EN, 1 without; busy high throughout.
- DIV a=200 b=7 -> result=0x041C, carry=0, latency 9; then DIV a=0x05 b=0 -> result=0x05FF, carry=1.
- ASR a=0x81 n=1 -> 0xC0, carry=1; LSR a=0x81 n=1 -> 0x40, carry=1; ROL a=0x81 n=1 -> 0x03, carry=0.
- Checks that a SUB with a=0x10 b=0x10 yields result=0x00, zero=1, ac=1, and:
  - out_ready low for 3 cycles -> result/flags stable, in_ready=0;
  - in_valid pulsed during that wait -> not accepted.
- Reset asserted at ITER cycle 4 of DIV -> next cycle all outputs 0, in_ready=1; a following ADD 1+1 -> result=0x0002.
